flash_word_ctrl: RTL

- Sits directly downstream of the host-command sequencer, between it and the 16-bit parallel NOR flash (Intel/Micron P30 command set).
- Turns single-word read/program requests into correctly timed flash bus cycles.
- Program requests run the full 0x0040/data/status-poll/read-array sequence.
- Returns read data or program status through a valid/ready response channel.

---
 rtl/flash_ctrl_pkg.sv | 28 ++
 rtl/flash_bus_cycle.sv | 93 +++++++++
 rtl/flash_word_ctrl.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/flash_ctrl_pkg.sv
// Shared constants, state encodings and status decode for the P30 NOR word controller.
package flash_ctrl_pkg;

   localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;
   localparam logic [15:0] CMD_PROGRAM    = 16'h0040;
   localparam logic [15:0] CMD_CLR_STATUS = 16'h0050;
   localparam logic [15:0] CMD_UNLOCK1    = 16'h0060;
   localparam logic [15:0] CMD_UNLOCK2    = 16'h00D0;

   localparam int unsigned SR_READY    = 7;
   localparam int unsigned SR_PROG_ERR = 4;
   localparam int unsigned SR_LOCK     = 1;

   typedef enum logic [3:0] {
      S_BOOT, S_INIT, S_IDLE, S_READ, S_UNLK1, S_UNLK2,
      S_PROG_CMD, S_PROG_DATA, S_POLL, S_CLR, S_RDARR, S_RESP
   } seq_state_t;

   typedef enum logic [2:0] {
      BC_IDLE, BC_SETUP, BC_PULSE, BC_HOLD, BC_READ
   } bus_state_t;

   // A finished program failed if the array reported a program error or a locked block.
   function automatic logic status_err(input logic [15:0] sr);
      return sr[SR_PROG_ERR] | sr[SR_LOCK];
   endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// One timed flash bus cycle: write (setup / WE pulse / hold) or read (OE low, sample on last cycle).
module flash_bus_cycle
   import flash_ctrl_pkg::*;
#(
   parameter int unsigned RD_CYCLES = 5,
   parameter int unsigned WE_CYCLES = 3
)(
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic        i_we,
   input  logic [15:0] i_wdata,
   input  logic [15:0] i_bus_data,
   output logic        o_done_c,
   output logic [15:0] o_rdata_c,
   output logic        o_oe_n,
   output logic        o_we_n,
   output logic        o_drive,
   output logic [15:0] o_wdata
);

   localparam int unsigned CW = 8;

   bus_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic          r_oe_n;
   logic          r_we_n;
   logic          r_drive;
   logic [15:0]   r_wdata;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= BC_IDLE;
         r_cnt   <= '0;
         r_oe_n  <= 1'b1;
         r_we_n  <= 1'b1;
         r_drive <= 1'b0;
         r_wdata <= '0;
      end else begin
         case (r_state)
            BC_IDLE: begin
               if (i_start) begin
                  r_cnt <= '0;
                  if (i_we) begin
                     r_state <= BC_SETUP;
                     r_drive <= 1'b1;
                     r_wdata <= i_wdata;
                  end else begin
                     r_state <= BC_READ;
                     r_oe_n  <= 1'b0;
                  end
               end
            end
            BC_SETUP: begin
               r_state <= BC_PULSE;
               r_we_n  <= 1'b0;
               r_cnt   <= '0;
            end
            BC_PULSE: begin
               if (r_cnt == CW'(WE_CYCLES - 1)) begin
                  r_state <= BC_HOLD;
                  r_we_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            BC_HOLD: begin
               r_state <= BC_IDLE;
               r_drive <= 1'b0;
            end
            BC_READ: begin
               if (r_cnt == CW'(RD_CYCLES - 1)) begin
                  r_state <= BC_IDLE;
                  r_oe_n  <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= BC_IDLE;
         endcase
      end
   end

   // Done is flagged during the final cycle so the sequencer can chain the next cycle with one idle gap.
   assign o_done_c  = (r_state == BC_HOLD) ||
                      ((r_state == BC_READ) && (r_cnt == CW'(RD_CYCLES - 1)));
   assign o_rdata_c = i_bus_data;
   assign o_oe_n    = r_oe_n;
   assign o_we_n    = r_we_n;
   assign o_drive   = r_drive;
   assign o_wdata   = r_wdata;

endmodule

// File: rtl/flash_word_ctrl.sv
// Single-word read/program sequencer for P30 NOR flash; FLASH_UNLOCK_EN adds block-unlock cycles before programming.
module flash_word_ctrl
   import flash_ctrl_pkg::*;
#(
   parameter int unsigned RD_CYCLES    = 5,
   parameter int unsigned WE_CYCLES    = 3,
   parameter logic [23:0] POLL_TIMEOUT = 24'd4_800_000
)(
   input  logic        fx2Clk_in,
   input  logic        resetN_in,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [23:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        rsp_err,
   output logic [25:0] flash_address,
   inout  wire  [15:0] flash_data,
   output logic        flash_oe_n,
   output logic        flash_we_n,
   output logic        flash_ce,
   output logic        flash_rst
);

`ifdef FLASH_UNLOCK_EN
   localparam seq_state_t PROG_FIRST = S_UNLK1;
`else
   localparam seq_state_t PROG_FIRST = S_PROG_CMD;
`endif

   seq_state_t  r_state;
   logic        r_start;
   logic [23:0] r_addr;
   logic [15:0] r_wdata;
   logic [23:0] r_poll_cnt;
   logic        r_req_ready;
   logic        r_rsp_valid;
   logic [15:0] r_rsp_data;
   logic        r_rsp_err;
   logic        r_ce;
   logic        r_frst;

   logic        w_done_c;
   logic [15:0] w_rdata_c;
   logic        w_oe_n;
   logic        w_we_n;
   logic        w_drive;
   logic [15:0] w_dout;
   logic [15:0] w_cmd;
   logic        w_we;

   // The launched cycle's kind and payload follow the state it was launched into.
   always_comb begin
      w_cmd = 16'h0000;
      case (r_state)
         S_INIT:      w_cmd = CMD_READ_ARRAY;
         S_UNLK1:     w_cmd = CMD_UNLOCK1;
         S_UNLK2:     w_cmd = CMD_UNLOCK2;
         S_PROG_CMD:  w_cmd = CMD_PROGRAM;
         S_PROG_DATA: w_cmd = r_wdata;
         S_CLR:       w_cmd = CMD_CLR_STATUS;
         S_RDARR:     w_cmd = CMD_READ_ARRAY;
         default:     w_cmd = 16'h0000;
      endcase
   end

   assign w_we = !((r_state == S_READ) || (r_state == S_POLL));

   flash_bus_cycle #(
      .RD_CYCLES (RD_CYCLES),
      .WE_CYCLES (WE_CYCLES)
   ) u_bus (
      .i_clk      (fx2Clk_in),
      .i_rst_n    (resetN_in),
      .i_start    (r_start),
      .i_we       (w_we),
      .i_wdata    (w_cmd),
      .i_bus_data (flash_data),
      .o_done_c   (w_done_c),
      .o_rdata_c  (w_rdata_c),
      .o_oe_n     (w_oe_n),
      .o_we_n     (w_we_n),
      .o_drive    (w_drive),
      .o_wdata    (w_dout)
   );

   always_ff @(posedge fx2Clk_in) begin
      if (!resetN_in) begin
         r_state     <= S_BOOT;
         r_start     <= 1'b0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_poll_cnt  <= '0;
         r_req_ready <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= '0;
         r_rsp_err   <= 1'b0;
         r_ce        <= 1'b1;
         r_frst      <= 1'b0;
      end else begin
         r_start <= 1'b0;
         r_ce    <= 1'b0;
         r_frst  <= 1'b1;
         case (r_state)
            S_BOOT: begin
               r_addr  <= '0;
               r_state <= S_INIT;
               r_start <= 1'b1;
            end
            S_INIT: begin
               if (w_done_c) begin
                  r_state     <= S_IDLE;
                  r_req_ready <= 1'b1;
               end
            end
            S_IDLE: begin
               if (req_valid && r_req_ready) begin
                  r_req_ready <= 1'b0;
                  r_addr      <= req_addr;
                  r_wdata     <= req_wdata;
                  r_rsp_err   <= 1'b0;
                  r_poll_cnt  <= '0;
                  r_start     <= 1'b1;
                  r_state     <= req_write ? PROG_FIRST : S_READ;
               end
            end
            S_READ: begin
               if (w_done_c) begin
                  r_rsp_data  <= w_rdata_c;
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_UNLK1: begin
               if (w_done_c) begin
                  r_state <= S_UNLK2;
                  r_start <= 1'b1;
               end
            end
            S_UNLK2: begin
               if (w_done_c) begin
                  r_state <= S_PROG_CMD;
                  r_start <= 1'b1;
               end
            end
            S_PROG_CMD: begin
               if (w_done_c) begin
                  r_state <= S_PROG_DATA;
                  r_start <= 1'b1;
               end
            end
            S_PROG_DATA: begin
               if (w_done_c) begin
                  r_state <= S_POLL;
                  r_start <= 1'b1;
               end
            end
            S_POLL: begin
               if (w_done_c) begin
                  r_rsp_data <= w_rdata_c;
                  r_start    <= 1'b1;
                  if (w_rdata_c[SR_READY]) begin
                     r_rsp_err <= status_err(w_rdata_c);
                     r_state   <= status_err(w_rdata_c) ? S_CLR : S_RDARR;
                  end else if (r_poll_cnt == POLL_TIMEOUT - 24'd1) begin
                     r_rsp_err <= 1'b1;
                     r_state   <= S_CLR;
                  end else begin
                     r_poll_cnt <= r_poll_cnt + 24'd1;
                  end
               end
            end
            S_CLR: begin
               if (w_done_c) begin
                  r_state <= S_RDARR;
                  r_start <= 1'b1;
               end
            end
            S_RDARR: begin
               if (w_done_c) begin
                  r_rsp_valid <= 1'b1;
                  r_state     <= S_RESP;
               end
            end
            S_RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_BOOT;
         endcase
      end
   end

   assign flash_data    = w_drive ? w_dout : 16'hzzzz;
   assign flash_address = {2'b00, r_addr};
   assign flash_oe_n    = w_oe_n;
   assign flash_we_n    = w_we_n;
   assign flash_ce      = r_ce;
   assign flash_rst     = r_frst;
   assign req_ready     = r_req_ready;
   assign rsp_valid     = r_rsp_valid;
   assign rsp_data      = r_rsp_data;
   assign rsp_err       = r_rsp_err;

endmodule
